// File: rtl/mem_ctrl_if.sv
// Request/response ports of the memory controller towards the icache and LSB,
// plus the byte-wide RAM/IO bus it drives.
interface mem_ctrl_if;
    logic        ic_ena;
    logic [31:0] ic_addr;
    logic        ic_valid;
    logic [31:0] ic_data;
    logic        lsb_ena;
    logic        lsb_wr;
    logic [1:0]  lsb_size;
    logic [31:0] lsb_addr;
    logic [31:0] lsb_wdata;
    logic        lsb_valid;
    logic [31:0] lsb_rdata;
    logic        io_buffer_full;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;

    modport master (
        output ic_ena, ic_addr, lsb_ena, lsb_wr, lsb_size, lsb_addr, lsb_wdata,
               io_buffer_full, mem_din,
        input  ic_valid, ic_data, lsb_valid, lsb_rdata, mem_dout, mem_a, mem_wr
    );

    modport slave (
        input  ic_ena, ic_addr, lsb_ena, lsb_wr, lsb_size, lsb_addr, lsb_wdata,
               io_buffer_full, mem_din,
        output ic_valid, ic_data, lsb_valid, lsb_rdata, mem_dout, mem_a, mem_wr
    );
endinterface

// File: rtl/mem_ctrl.sv
// Serialises icache word fetches and LSB byte/half/word loads/stores onto a
// byte-wide single-port RAM bus and returns the assembled 32-bit result.
module mem_ctrl (
    input  logic      clk,
    input  logic      rst,
    input  logic      rdy,
    mem_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t      state_r;
    logic [31:0] base_r;
    logic [31:0] wdata_r;
    logic [31:0] rd_buf_r;
    logic [2:0]  len_r;
    logic [2:0]  cnt_r;
    logic        owner_lsb_r;
    logic [7:0]  hold_r;
    logic        hold_v_r;
    logic        ic_valid_r;
    logic        lsb_valid_r;
    logic        mem_wr_r;
    logic [31:0] ic_data_r;
    logic [31:0] lsb_rdata_r;
    logic [31:0] mem_a_r;
    logic [7:0]  mem_dout_r;

    logic [2:0]  lsb_len_s;
    logic [2:0]  next_cnt_s;
    logic [31:0] next_addr_s;
    logic [1:0]  cap_idx_s;
    logic [7:0]  cap_byte_s;
    logic [31:0] merged_s;
    logic        lsb_blocked_s;

    // Byte count of an LSB request; size 3 behaves as a word.
    always_comb begin
        lsb_len_s = 3'd4;
        case (bus.lsb_size)
            2'd0:    lsb_len_s = 3'd1;
            2'd1:    lsb_len_s = 3'd2;
            default: lsb_len_s = 3'd4;
        endcase
    end

    // Next bus address and merge of the byte arriving on mem_din (cnt_r counts cycles in READ, so byte cnt_r-1 is arriving).
    always_comb begin
        lsb_blocked_s = bus.lsb_wr && (bus.lsb_addr[17:16] == 2'b11) && bus.io_buffer_full;
        next_cnt_s    = cnt_r + 3'd1;
        next_addr_s   = base_r + {29'd0, next_cnt_s};
        cap_idx_s     = cnt_r[1:0] - 2'd1;
        if (hold_v_r) begin
            cap_byte_s = hold_r;
        end else begin
            cap_byte_s = bus.mem_din;
        end
        merged_s = rd_buf_r;
        merged_s[{cap_idx_s, 3'b000} +: 8] = cap_byte_s;
    end

    // Controller FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            base_r      <= 32'd0;
            wdata_r     <= 32'd0;
            rd_buf_r    <= 32'd0;
            len_r       <= 3'd0;
            cnt_r       <= 3'd0;
            owner_lsb_r <= 1'b0;
            hold_r      <= 8'd0;
            hold_v_r    <= 1'b0;
            ic_valid_r  <= 1'b0;
            lsb_valid_r <= 1'b0;
            ic_data_r   <= 32'd0;
            lsb_rdata_r <= 32'd0;
            mem_a_r     <= 32'd0;
            mem_dout_r  <= 8'd0;
            mem_wr_r    <= 1'b0;
        end else if (!rdy) begin
            // The RAM keeps running while paused: keep the byte that was due so the next one cannot overwrite it.
            if (state_r == READ && cnt_r != 3'd0 && !hold_v_r) begin
                hold_r   <= bus.mem_din;
                hold_v_r <= 1'b1;
            end
        end else begin
            hold_v_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    cnt_r    <= 3'd0;
                    rd_buf_r <= 32'd0;
                    if (bus.lsb_ena && !lsb_blocked_s) begin
                        base_r      <= bus.lsb_addr;
                        len_r       <= lsb_len_s;
                        wdata_r     <= bus.lsb_wdata;
                        owner_lsb_r <= 1'b1;
                        mem_a_r     <= bus.lsb_addr;
                        if (bus.lsb_wr) begin
                            state_r    <= WRITE;
                            mem_dout_r <= bus.lsb_wdata[7:0];
                            mem_wr_r   <= 1'b1;
                        end else begin
                            state_r    <= READ;
                            mem_dout_r <= 8'd0;
                            mem_wr_r   <= 1'b0;
                        end
                    end else if (bus.ic_ena) begin
                        base_r      <= bus.ic_addr;
                        len_r       <= 3'd4;
                        owner_lsb_r <= 1'b0;
                        mem_a_r     <= bus.ic_addr;
                        mem_dout_r  <= 8'd0;
                        mem_wr_r    <= 1'b0;
                        state_r     <= READ;
                    end else begin
                        mem_a_r    <= 32'd0;
                        mem_dout_r <= 8'd0;
                        mem_wr_r   <= 1'b0;
                        state_r    <= IDLE;
                    end
                end
                READ: begin
                    cnt_r <= next_cnt_s;
                    if (cnt_r != 3'd0) begin
                        rd_buf_r <= merged_s;
                    end
                    if (next_cnt_s < len_r) begin
                        mem_a_r <= next_addr_s;
                    end else begin
                        mem_a_r <= 32'd0;
                    end
                    if (cnt_r == len_r) begin
                        if (owner_lsb_r) begin
                            lsb_rdata_r <= merged_s;
                            lsb_valid_r <= 1'b1;
                        end else begin
                            ic_data_r  <= merged_s;
                            ic_valid_r <= 1'b1;
                        end
                        state_r <= DONE;
                    end
                end
                WRITE: begin
                    if (next_cnt_s < len_r) begin
                        cnt_r      <= next_cnt_s;
                        mem_a_r    <= next_addr_s;
                        mem_dout_r <= wdata_r[{next_cnt_s[1:0], 3'b000} +: 8];
                        mem_wr_r   <= 1'b1;
                    end else begin
                        mem_a_r     <= 32'd0;
                        mem_dout_r  <= 8'd0;
                        mem_wr_r    <= 1'b0;
                        lsb_valid_r <= 1'b1;
                        state_r     <= DONE;
                    end
                end
                DONE: begin
                    ic_valid_r  <= 1'b0;
                    lsb_valid_r <= 1'b0;
                    state_r     <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign bus.ic_valid  = ic_valid_r;
    assign bus.ic_data   = ic_data_r;
    assign bus.lsb_valid = lsb_valid_r;
    assign bus.lsb_rdata = lsb_rdata_r;
    assign bus.mem_a     = mem_a_r;
    assign bus.mem_dout  = mem_dout_r;
    // A paused write must not strobe the RAM; the same byte is re-driven on resume.
    assign bus.mem_wr    = mem_wr_r & rdy;
endmodule
